twofish_subkey_gen: RTL and testbench
=====================================

# twofish_subkey_gen

Iterative Twofish-128 round-subkey generator. Latches a 128-bit key and produces the 40 expanded words K0..K39 as 20 pairs over a valid/ready stream. Pairs come out in ascending order for the encryption datapath or descending order for the decryption datapath. The block sits beside the key-schedule logic that derives the S-box key vector, and it feeds the round pipeline. It uses a single h-function instance, shared across cycles.

## Interface
- `RHO`, default 32'h01010101: h-function index step ρ.
- `MDS_POLY`, default 9'h169: GF(2^8) reduction polynomial for the MDS multiply.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. Synchronous and active-high; one clock, no other clock domains.
- `start` in 1: begin expansion. Sampled only in IDLE.
- `key` in 128: cipher key, byte 0 = `key[7:0]`. Latched on accepted `start`.
- `dir` in 1: 0 = ascending (pair 0 first), 1 = descending (pair 19 first). Latched with `key`.
- `subkey` out 64: `{K(2i+1), K(2i)}`.
- `pair_idx` out 5: index i of the pair presented on `subkey`.
- `out_valid` out 1: `subkey` and `pair_idx` are valid.
- `out_ready` in 1: consumer accepts the pair.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the 20th handshake.

## Operation
- Key words: Me0 = `key[31:0]`, Mo0 = `key[63:32]`, Me1 = `key[95:64]`, Mo1 = `key[127:96]`.
- Per pair i:
  - A = h(2i·ρ, Me1, Me0).
  - B = ROL(h((2i+1)·ρ, Mo1, Mo0), 8).
  - K(2i) = (A+B) mod 2^32.
  - K(2i+1) = ROL((A+2B) mod 2^32, 9).
- h(X, L1, L0), with bytes x0..x3 = LSB first and l1_j, l0_j = byte j of L1, L0:
  - y0 = q1[q0[q0[x0]^l1_0]^l0_0]
  - y1 = q0[q0[q1[x1]^l1_1]^l0_1]
  - y2 = q1[q1[q0[x2]^l1_2]^l0_2]
  - y3 = q0[q1[q1[x3]^l1_3]^l0_3]
  - Result is MDS·[y0..y3] over GF(2^8) modulo `MDS_POLY`.
- q0 and q1 are the standard Twofish 4-bit-nibble permutations. Both are combinational.
- States:
  - IDLE: `start` latches key and dir. Counter loads 0 (asc) or 19 (desc). Go to CALC_A.
  - CALC_A: h evaluated with the even index; result registered as A. Go to CALC_B.
  - CALC_B: h evaluated with the odd index. The K pair is formed and registered into `subkey`/`pair_idx`. Go to OUT.
  - OUT: `out_valid`=1. On `out_ready`: if the last pair (19 asc / 0 desc), go to IDLE and pulse `done`; otherwise step the counter ±1 and go to CALC_A.
- While `out_valid`=1 and `out_ready`=0, `subkey` and `pair_idx` hold stable. No prefetch is performed.
- `start` outside IDLE is ignored. Key/dir changes after latch have no effect.
- `rst` at any time (mid-expansion or mid-handshake) returns the block to IDLE within one edge. The stream is abandoned; no `done` is issued.

## Timing
- Reset values: `subkey`=0, `pair_idx`=0, `out_valid`=0, `busy`=0, `done`=0. Internal A, counter, key and dir registers = 0.
- `start` is sampled high at edge 0:
  - `busy`=1 from cycle 1.
  - First `out_valid` at cycle 3.
- Throughput is 3 cycles per pair with `out_ready` held high. All 20 pairs are handshaken by cycle 60.
- `done`=1 in the cycle after the final handshake, with `busy`=0 in that same cycle.
- A new `start` is accepted in the same cycle that `done` is high.
- The h/MDS path is single-cycle combinational. No output is combinationally dependent on `out_ready`.

## Test plan
- **Zero key, ascending.** `key`=0, `dir`=0, ready high:
  - pair 0 = {11F0626D, 52C54DDE}, pair 1 = {4D1B4AAA, 7CAC9D4A};
  - pair 2 = {1E7D0BEB, B7B83A10}, pair 3 = {CFE14BE4, EE9C341F};
  - `pair_idx` runs 0..19; `done` fires at cycle 61.
- **Zero key, descending.** `dir`=1:
  - `pair_idx` runs 19..0;
  - the last pair equals {11F0626D, 52C54DDE};
  - the 20-pair set matches the ascending run in reverse.
- **Backpressure.** Randomised `out_ready` (30% high):
  - `subkey`/`pair_idx` stay stable while valid and not ready;
  - the sequence is identical to the ready-high run;
  - exactly 20 handshakes, one `done`.
- **Reset mid-operation.** Assert `rst` at the pair 7 OUT state:
  - next cycle all outputs are at reset values and state is IDLE;
  - a fresh `start` restarts from pair 0.
- **Ignored start.** Pulse `start` with a different key during pair 5:
  - the output stream is unaffected;
  - a random nonzero key checked against the software model matches all 40 words.

Source files
------------

// File: rtl/twofish_subkey_gen.sv
// Iterative Twofish-128 round-subkey generator: one shared h-function, 3 cycles per K pair.
module twofish_subkey_gen #(
  parameter logic [31:0] RHO      = 32'h01010101,
  parameter logic [8:0]  MDS_POLY = 9'h169
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         dir,
  output logic [63:0]  subkey,
  output logic [4:0]   pair_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int unsigned IW   = 5;
  localparam int unsigned LAST = 19;

  // q0/q1 nibble permutation tables, entry 0 in the top nibble
  localparam logic [63:0] Q0_T0 = 64'h817D6F320B59ECA4;
  localparam logic [63:0] Q0_T1 = 64'hECB81235F4A6709D;
  localparam logic [63:0] Q0_T2 = 64'hBA5E6D90C8F32471;
  localparam logic [63:0] Q0_T3 = 64'hD7F4126E9B3085CA;
  localparam logic [63:0] Q1_T0 = 64'h28BDF76E31940AC5;
  localparam logic [63:0] Q1_T1 = 64'h1E2B4C376DA5F908;
  localparam logic [63:0] Q1_T2 = 64'h4C75169A0ED82B3F;
  localparam logic [63:0] Q1_T3 = 64'hB951C3DE647F208A;

  typedef enum logic [1:0] {IDLE, CALC_A, CALC_B, OUT} state_t;

  // Table lookup: entry n sits at bit offset 4*(15-n)
  function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] n);
    logic [63:0] s;
    s = tbl >> {~n, 2'b00};
    return s[3:0];
  endfunction

  // q permutation; sel=0 -> q0, sel=1 -> q1
  function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] x);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
    a2 = nib(sel ? Q1_T0 : Q0_T0, a1);
    b2 = nib(sel ? Q1_T1 : Q0_T1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    a4 = nib(sel ? Q1_T2 : Q0_T2, a3);
    b4 = nib(sel ? Q1_T3 : Q0_T3, b3);
    return {b4, a4};
  endfunction

  // GF(2^8) multiply reduced by MDS_POLY
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ MDS_POLY[7:0]) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // h function for a two-word key list followed by the MDS multiply
  function automatic logic [31:0] h_fn(input logic [31:0] x, input logic [31:0] l1,
                                       input logic [31:0] l0);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    y0 = q_perm(1'b1, q_perm(1'b0, q_perm(1'b0, x[7:0])   ^ l1[7:0])   ^ l0[7:0]);
    y1 = q_perm(1'b0, q_perm(1'b0, q_perm(1'b1, x[15:8])  ^ l1[15:8])  ^ l0[15:8]);
    y2 = q_perm(1'b1, q_perm(1'b1, q_perm(1'b0, x[23:16]) ^ l1[23:16]) ^ l0[23:16]);
    y3 = q_perm(1'b0, q_perm(1'b1, q_perm(1'b1, x[31:24]) ^ l1[31:24]) ^ l0[31:24]);
    z0 = y0 ^ gf_mul(8'hEF, y1) ^ gf_mul(8'h5B, y2) ^ gf_mul(8'h5B, y3);
    z1 = gf_mul(8'h5B, y0) ^ gf_mul(8'hEF, y1) ^ gf_mul(8'hEF, y2) ^ y3;
    z2 = gf_mul(8'hEF, y0) ^ gf_mul(8'h5B, y1) ^ y2 ^ gf_mul(8'hEF, y3);
    z3 = gf_mul(8'hEF, y0) ^ y1 ^ gf_mul(8'hEF, y2) ^ gf_mul(8'h5B, y3);
    return {z3, z2, z1, z0};
  endfunction

  state_t          state, state_n;
  logic [127:0]    key_r, key_n;
  logic            dir_r, dir_n;
  logic [IW-1:0]   cnt, cnt_n;
  logic [31:0]     a_r, a_n;
  logic [63:0]     subkey_n;
  logic [IW-1:0]   pair_idx_n;
  logic            out_valid_n, busy_n, done_n;

  logic [IW:0]     idx_c;
  logic [31:0]     h_x_c, h_l1_c, h_l0_c, h_out_c, b_c, sum1_c, sum2_c, k1_c;
  logic            last_c;

  // Shared h datapath: even index with Me words in CALC_A, odd index with Mo words in CALC_B
  always_comb begin
    idx_c   = {cnt, (state == CALC_B)};
    h_x_c   = 32'(idx_c) * RHO;
    h_l1_c  = (state == CALC_B) ? key_r[127:96] : key_r[95:64];
    h_l0_c  = (state == CALC_B) ? key_r[63:32]  : key_r[31:0];
    h_out_c = h_fn(h_x_c, h_l1_c, h_l0_c);
    b_c     = {h_out_c[23:0], h_out_c[31:24]};
    sum1_c  = a_r + b_c;
    sum2_c  = a_r + {b_c[30:0], 1'b0};
    k1_c    = {sum2_c[22:0], sum2_c[31:23]};
    last_c  = dir_r ? (cnt == '0) : (cnt == IW'(LAST));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n     = state;
    key_n       = key_r;
    dir_n       = dir_r;
    cnt_n       = cnt;
    a_n         = a_r;
    subkey_n    = subkey;
    pair_idx_n  = pair_idx;
    out_valid_n = out_valid;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_n   = key;
          dir_n   = dir;
          cnt_n   = dir ? IW'(LAST) : '0;
          state_n = CALC_A;
        end
      end
      CALC_A: begin
        a_n     = h_out_c;
        state_n = CALC_B;
      end
      CALC_B: begin
        subkey_n    = {k1_c, sum1_c};
        pair_idx_n  = cnt;
        out_valid_n = 1'b1;
        state_n     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          if (last_c) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n   = dir_r ? (cnt - IW'(1)) : (cnt + IW'(1));
            state_n = CALC_A;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_r     <= '0;
      dir_r     <= 1'b0;
      cnt       <= '0;
      a_r       <= '0;
      subkey    <= '0;
      pair_idx  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      key_r     <= key_n;
      dir_r     <= dir_n;
      cnt       <= cnt_n;
      a_r       <= a_n;
      subkey    <= subkey_n;
      pair_idx  <= pair_idx_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_twofish_subkey_gen.sv
// Bench for twofish_subkey_gen: software key-schedule model, scoreboard queue, known-answer table.
module tb_twofish_subkey_gen;

  localparam logic [31:0] RHO_TB  = 32'h01010101;
  localparam logic [7:0]  POLY_LO = 8'h69;

  logic         clk = 1'b0;
  logic         rst, start, dir, out_ready;
  logic [127:0] key;
  logic [63:0]  subkey;
  logic [4:0]   pair_idx;
  logic         out_valid, busy, done;

  twofish_subkey_gen dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .dir(dir),
    .subkey(subkey), .pair_idx(pair_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] idx; logic [63:0] sk; } exp_t;
  typedef struct { logic dir; int idx; logic [63:0] sk; } vec_t;

  exp_t        exp_q[$];
  logic [63:0] got_sk   [20];
  logic [63:0] got_asc  [20];
  logic [63:0] got_desc [20];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- software model ----------------
  function automatic logic [3:0] m_t(input int q, input int t, input logic [3:0] n);
    logic [63:0] tbl;
    case (q * 4 + t)
      0: tbl = 64'h817D6F320B59ECA4;
      1: tbl = 64'hECB81235F4A6709D;
      2: tbl = 64'hBA5E6D90C8F32471;
      3: tbl = 64'hD7F4126E9B3085CA;
      4: tbl = 64'h28BDF76E31940AC5;
      5: tbl = 64'h1E2B4C376DA5F908;
      6: tbl = 64'h4C75169A0ED82B3F;
      7: tbl = 64'hB951C3DE647F208A;
      default: tbl = '0;
    endcase
    return 4'(tbl >> (60 - 4 * int'(n)));
  endfunction

  function automatic logic [7:0] m_q(input int q, input logic [7:0] x);
    logic [3:0] a, b, a2, b2, a3, b3;
    a  = x[7:4] ^ x[3:0];
    b  = x[7:4] ^ {x[0], x[3:1]} ^ {x[4], 3'b000};
    a2 = m_t(q, 0, a);
    b2 = m_t(q, 1, b);
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    return {m_t(q, 3, b3), m_t(q, 2, a3)};
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 7; i >= 0; i--) begin
      p = p[7] ? ({p[6:0], 1'b0} ^ POLY_LO) : {p[6:0], 1'b0};
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  function automatic logic [31:0] m_h(input logic [31:0] x, input logic [31:0] l1, input logic [31:0] l0);
    int inner[4] = '{0, 1, 0, 1};
    int mid[4]   = '{0, 0, 1, 1};
    int outer[4] = '{1, 0, 1, 0};
    logic [7:0] mds[4][4] = '{'{8'h01, 8'hEF, 8'h5B, 8'h5B},
                              '{8'h5B, 8'hEF, 8'hEF, 8'h01},
                              '{8'hEF, 8'h5B, 8'h01, 8'hEF},
                              '{8'hEF, 8'h01, 8'hEF, 8'h5B}};
    logic [7:0] y[4];
    logic [7:0] t, z;
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++) begin
      t    = m_q(inner[j], x[8*j +: 8]) ^ l1[8*j +: 8];
      t    = m_q(mid[j], t) ^ l0[8*j +: 8];
      y[j] = m_q(outer[j], t);
    end
    for (int i = 0; i < 4; i++) begin
      z = '0;
      for (int j = 0; j < 4; j++) z = z ^ m_mul(mds[i][j], y[j]);
      r[8*i +: 8] = z;
    end
    return r;
  endfunction

  function automatic logic [63:0] m_pair(input logic [127:0] k, input int i);
    logic [31:0] a, hb, b, k0, t, k1;
    a  = m_h(32'(2 * i) * RHO_TB, k[95:64], k[31:0]);
    hb = m_h(32'(2 * i + 1) * RHO_TB, k[127:96], k[63:32]);
    b  = (hb << 8) | (hb >> 24);
    k0 = a + b;
    t  = a + b + b;
    k1 = (t << 9) | (t >> 23);
    return {k1, k0};
  endfunction

  // ---------------- stream runner ----------------
  // mode 0: out_ready held high; mode 1: out_ready random ~30% high
  task automatic run_stream(input logic [127:0] k, input logic d, input int mode,
                            input bit chk_timing, input bit inject);
    int e = 0, hs = 0, first_valid = -1, extra_done = 0, budget;
    bit got_done = 0, prev_hold = 0, pend = 0, injected = 0;
    logic [63:0] prev_sk;
    logic [4:0]  prev_idx;
    exp_t ex;
    budget = (mode == 0) ? 400 : 2000;
    for (int j = 0; j < 20; j++) begin
      int ix = d ? 19 - j : j;
      exp_q.push_back('{idx: 5'(ix), sk: m_pair(k, ix)});
    end
    @(posedge clk); #1;
    start = 1'b1; key = k; dir = d;
    out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    @(posedge clk); #1;
    start = 1'b0; key = {$urandom, $urandom, $urandom, $urandom}; dir = ~d;
    while (!got_done && e < budget) begin
      @(negedge clk);
      if (chk_timing && e == 0) check("busy_cycle1", 64'(busy), 64'd1);
      if (out_valid && first_valid < 0) first_valid = e;
      if (prev_hold) begin
        check("hold_subkey", subkey, prev_sk);
        check("hold_idx", 64'(pair_idx), 64'(prev_idx));
      end
      if (done) begin
        got_done = 1;
        check("busy_at_done", 64'(busy), 64'd0);
        if (chk_timing) check("done_cycle", 64'(e + 1), 64'd61);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_pair", 64'd1, 64'd0);
        else begin
          ex = exp_q.pop_front();
          check($sformatf("pair_idx_seq%0d", hs), 64'(pair_idx), 64'(ex.idx));
          check($sformatf("subkey[%0d]", ex.idx), subkey, ex.sk);
        end
        got_sk[pair_idx] = subkey;
        hs++;
      end
      if (out_valid && pair_idx == 5'd5 && inject && !injected) pend = 1;
      prev_hold = out_valid && !out_ready;
      prev_sk   = subkey;
      prev_idx  = pair_idx;
      @(posedge clk); e++; #1;
      if (mode == 1) out_ready = ($urandom_range(0, 9) < 3);
      if (pend) begin
        start = 1'b1; key = {$urandom, $urandom, 32'hDEAD_BEEF, $urandom};
        pend = 0; injected = 1;
      end else start = 1'b0;
    end
    check("done_seen", 64'(got_done), 64'd1);
    check("handshakes", 64'(hs), 64'd20);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    if (chk_timing) check("first_valid_cycle", 64'(first_valid + 1), 64'd3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("single_done", 64'(extra_done), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  vec_t vt[5];
  bit found;

  initial begin
    vt[0] = '{dir: 1'b0, idx: 0, sk: {32'h11F0626D, 32'h52C54DDE}};
    vt[1] = '{dir: 1'b0, idx: 1, sk: {32'h4D1B4AAA, 32'h7CAC9D4A}};
    vt[2] = '{dir: 1'b0, idx: 2, sk: {32'h1E7D0BEB, 32'hB7B83A10}};
    vt[3] = '{dir: 1'b0, idx: 3, sk: {32'hCFE14BE4, 32'hEE9C341F}};
    vt[4] = '{dir: 1'b1, idx: 0, sk: {32'h11F0626D, 32'h52C54DDE}};

    rst = 1'b1; start = 1'b0; dir = 1'b0; out_ready = 1'b0; key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_subkey", subkey, 64'd0);
    check("rst_pair_idx", 64'(pair_idx), 64'd0);
    check("rst_valid_busy_done", 64'({out_valid, busy, done}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Zero key, ascending then descending, ready high
    run_stream('0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) got_asc[i] = got_sk[i];
    run_stream('0, 1'b1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) got_desc[i] = got_sk[i];

    // Known-answer table against captured DUT pairs
    for (int v = 0; v < 5; v++)
      check($sformatf("kat_dir%0d_pair%0d", vt[v].dir, vt[v].idx),
            vt[v].dir ? got_desc[vt[v].idx] : got_asc[vt[v].idx], vt[v].sk);

    // Backpressure with random ready
    run_stream('0, 1'b0, 1, 1'b0, 1'b0);

    // Reset while pair 7 is presented
    @(posedge clk); #1;
    start = 1'b1; key = '0; dir = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (out_valid && pair_idx == 5'd7) found = 1;
    end
    check("reach_pair7", 64'(found), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_subkey", subkey, 64'd0);
    check("midrst_pair_idx", 64'(pair_idx), 64'd0);
    check("midrst_valid_busy_done", 64'({out_valid, busy, done}), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_idle", 64'({out_valid, busy, done}), 64'd0);
    end
    run_stream('0, 1'b0, 0, 1'b1, 1'b0);

    // Random key with an ignored start during pair 5, both directions
    run_stream({$urandom, $urandom, $urandom, $urandom | 32'd1}, 1'b0, 0, 1'b1, 1'b1);
    run_stream({$urandom, $urandom, $urandom, $urandom | 32'd1}, 1'b1, 1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
